dram_ctrl_gen: RTL and testbench

Parametrised second-generation DRAM controller for the multi-design chip: turns a CPU-side async-style request (CSn/RWn/addr) into multiplexed RAS/CAS cycles on a DRAM address bus of ADDR_W/2 bits. Compared with the 16-bit first generation it adds width generalisation, runtime-programmable timing via the CONFn register, automatic CAS-before-RAS refresh, and an optional open-page mode. Sits between the chip's bidirectional pad ring and external DRAM plus read/write data latches.

---
 rtl/dram_ctrl_gen.sv | 291 +++++++++++++++++++++++++++++
 tb/tb_dram_ctrl_gen.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dram_ctrl_gen.sv
// rtl/dram_ctrl_gen.sv - multiplexed RAS/CAS DRAM controller with programmable timing and CBR refresh
//
// Turns a CPU-side CSn/RWn/addr request into a row/column multiplexed DRAM cycle.
// Timing (tRCD, tCAS, tRP) comes from an 8-bit config register written with CSn=0, CONFn=0.
// A free-running counter requests a CAS-before-RAS refresh every REFRESH_CYCLES clocks.
// Optional feature macro: DRAMC_PAGE_MODE_EN (open-page mode, row kept open after CAS).
//
// Parameters:
//   ADDR_W          CPU address width (even, 8..24); DRAM address bus is ADDR_W/2 wide
//   REFRESH_CYCLES  clocks between refresh requests (>= 16)
// Ports:
//   clk             clock, rising edge
//   RESETn          asynchronous active-low reset
//   addr            CPU address: row = upper half, column = lower half
//   CSn, RWn, CONFn request strobe, read(1)/write(0), config-write select
//   DA              multiplexed DRAM address
//   RASn, CASn, DWn DRAM strobes and write enable, active low
//   RDY             1 = idle or access complete
//   BEn             data bus buffer enable, active low
//   RLE, WLE        read/write data latch enable pulses
module dram_ctrl_gen #(
  parameter int ADDR_W         = 16,
  parameter int REFRESH_CYCLES = 256
) (
  input  logic                clk,
  input  logic                RESETn,
  input  logic [ADDR_W-1:0]   addr,
  input  logic                CSn,
  input  logic                RWn,
  input  logic                CONFn,
  output logic [ADDR_W/2-1:0] DA,
  output logic                RASn,
  output logic                CASn,
  output logic                DWn,
  output logic                RDY,
  output logic                BEn,
  output logic                RLE,
  output logic                WLE
);

  localparam int MUX_W = ADDR_W / 2;
  localparam int CNT_W = $clog2(REFRESH_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(REFRESH_CYCLES - 1);
  localparam logic [7:0]       CFG_RESET = 8'h48;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RAS,
    S_CAS,
    S_PRE,
    S_REF_CAS,
`ifdef DRAMC_PAGE_MODE_EN
    S_REF_RAS,
    S_PAGE
`else
    S_REF_RAS
`endif
  } state_t;

  state_t             state_q, state_d;
  logic [2:0]         timer_q, timer_d;
  logic [7:0]         cfg_q, cfg_d;
  logic [CNT_W-1:0]   ref_cnt_q, ref_cnt_d;
  logic               pend_q, pend_d;
  logic               armed_q, armed_d;
  logic [MUX_W-1:0]   row_q, row_d;
  logic [MUX_W-1:0]   col_q, col_d;
  logic               rw_q, rw_d;

  // Request inputs are registered once before the FSM looks at them.
  logic               in_csn_q, in_csn_d;
  logic               in_rwn_q, in_rwn_d;
  logic               in_confn_q, in_confn_d;
  logic [ADDR_W-1:0]  in_addr_q, in_addr_d;

  logic [MUX_W-1:0]   da_q, da_d;
  logic               rasn_q, rasn_d;
  logic               casn_q, casn_d;
  logic               dwn_q, dwn_d;
  logic               rdy_q, rdy_d;
  logic               ben_q, ben_d;
  logic               rle_q, rle_d;
  logic               wle_q, wle_d;

  logic               wrap;
  logic               req_cfg;
  logic               req_acc;

  assign wrap    = (ref_cnt_q == CNT_MAX);
  assign req_cfg = ~in_csn_q & ~in_confn_q;
  // armed_q makes a held-low CSn produce exactly one access.
  assign req_acc = ~in_csn_q & in_confn_q & armed_q;

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    cfg_d      = cfg_q;
    row_d      = row_q;
    col_d      = col_q;
    rw_d       = rw_q;
    in_csn_d   = CSn;
    in_rwn_d   = RWn;
    in_confn_d = CONFn;
    in_addr_d  = addr;
    ref_cnt_d  = wrap ? '0 : ref_cnt_q + CNT_W'(1);
    // A wrap while already pending just leaves the single request pending.
    pend_d     = pend_q | wrap;
    armed_d    = armed_q | in_csn_q;
    rle_d      = 1'b0;
    wle_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (pend_q) begin
          state_d = S_REF_CAS;
          pend_d  = wrap;
        end else if (req_cfg) begin
          cfg_d = in_addr_q[7:0];
        end else if (req_acc) begin
          state_d = S_RAS;
          timer_d = cfg_q[2:0];
          row_d   = in_addr_q[ADDR_W-1:MUX_W];
          col_d   = in_addr_q[MUX_W-1:0];
          rw_d    = in_rwn_q;
          armed_d = 1'b0;
          wle_d   = ~in_rwn_q;
        end
      end
      S_RAS: begin
        if (timer_q == 3'd0) begin
          state_d = S_CAS;
          timer_d = cfg_q[5:3];
          rle_d   = rw_q & (cfg_q[5:3] == 3'd0);
        end else begin
          timer_d = timer_q - 3'd1;
        end
      end
      S_CAS: begin
        if (timer_q == 3'd0) begin
`ifdef DRAMC_PAGE_MODE_EN
          state_d = S_PAGE;
`else
          state_d = S_PRE;
          timer_d = {1'b0, cfg_q[7:6]};
`endif
        end else begin
          timer_d = timer_q - 3'd1;
          // RLE lands in the final CAS cycle, i.e. when one count remains.
          rle_d   = rw_q & (timer_q == 3'd1);
        end
      end
      S_PRE: begin
        if (timer_q == 3'd0) begin
          state_d = S_IDLE;
        end else begin
          timer_d = timer_q - 3'd1;
        end
      end
      S_REF_CAS: begin
        state_d = S_REF_RAS;
        timer_d = cfg_q[5:3];
      end
      S_REF_RAS: begin
        if (timer_q == 3'd0) begin
          state_d = S_PRE;
          timer_d = {1'b0, cfg_q[7:6]};
        end else begin
          timer_d = timer_q - 3'd1;
        end
      end
`ifdef DRAMC_PAGE_MODE_EN
      S_PAGE: begin
        // Anything other than a row hit closes the page; the request is
        // then served from IDLE because armed_q is still set.
        if (pend_q || req_cfg || (req_acc && (in_addr_q[ADDR_W-1:MUX_W] != row_q))) begin
          state_d = S_PRE;
          timer_d = {1'b0, cfg_q[7:6]};
        end else if (req_acc) begin
          state_d = S_CAS;
          timer_d = cfg_q[5:3];
          col_d   = in_addr_q[MUX_W-1:0];
          rw_d    = in_rwn_q;
          armed_d = 1'b0;
          wle_d   = ~in_rwn_q;
          rle_d   = in_rwn_q & (cfg_q[5:3] == 3'd0);
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase

    // Strobe levels follow the state being entered so every output is a flop.
    da_d   = '0;
    rasn_d = 1'b1;
    casn_d = 1'b1;
    dwn_d  = 1'b1;
    rdy_d  = 1'b1;
    ben_d  = 1'b1;
    case (state_d)
      S_RAS: begin
        da_d   = row_d;
        rasn_d = 1'b0;
        rdy_d  = 1'b0;
        ben_d  = 1'b0;
      end
      S_CAS: begin
        da_d   = col_d;
        rasn_d = 1'b0;
        casn_d = 1'b0;
        dwn_d  = rw_d;
        rdy_d  = 1'b0;
        ben_d  = 1'b0;
      end
      S_REF_CAS: begin
        casn_d = 1'b0;
        rdy_d  = 1'b0;
      end
      S_REF_RAS: begin
        rasn_d = 1'b0;
        casn_d = 1'b0;
        rdy_d  = 1'b0;
      end
`ifdef DRAMC_PAGE_MODE_EN
      S_PAGE: begin
        rasn_d = 1'b0;
      end
`endif
      default: begin
        da_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge RESETn) begin
    if (!RESETn) begin
      state_q    <= S_IDLE;
      timer_q    <= '0;
      cfg_q      <= CFG_RESET;
      ref_cnt_q  <= '0;
      pend_q     <= 1'b0;
      armed_q    <= 1'b1;
      row_q      <= '0;
      col_q      <= '0;
      rw_q       <= 1'b1;
      in_csn_q   <= 1'b1;
      in_rwn_q   <= 1'b1;
      in_confn_q <= 1'b1;
      in_addr_q  <= '0;
      da_q       <= '0;
      rasn_q     <= 1'b1;
      casn_q     <= 1'b1;
      dwn_q      <= 1'b1;
      rdy_q      <= 1'b1;
      ben_q      <= 1'b1;
      rle_q      <= 1'b0;
      wle_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      cfg_q      <= cfg_d;
      ref_cnt_q  <= ref_cnt_d;
      pend_q     <= pend_d;
      armed_q    <= armed_d;
      row_q      <= row_d;
      col_q      <= col_d;
      rw_q       <= rw_d;
      in_csn_q   <= in_csn_d;
      in_rwn_q   <= in_rwn_d;
      in_confn_q <= in_confn_d;
      in_addr_q  <= in_addr_d;
      da_q       <= da_d;
      rasn_q     <= rasn_d;
      casn_q     <= casn_d;
      dwn_q      <= dwn_d;
      rdy_q      <= rdy_d;
      ben_q      <= ben_d;
      rle_q      <= rle_d;
      wle_q      <= wle_d;
    end
  end

  assign DA   = da_q;
  assign RASn = rasn_q;
  assign CASn = casn_q;
  assign DWn  = dwn_q;
  assign RDY  = rdy_q;
  assign BEn  = ben_q;
  assign RLE  = rle_q;
  assign WLE  = wle_q;

endmodule

// File: tb/tb_dram_ctrl_gen.sv
// tb/tb_dram_ctrl_gen.sv - self-checking bench for dram_ctrl_gen
module tb_dram_ctrl_gen;

  localparam int ADDR_W = 16;
  localparam int MUX_W  = ADDR_W / 2;
  localparam int RC     = 32;

  logic              clk;
  logic              RESETn;
  logic [ADDR_W-1:0] addr;
  logic              CSn, RWn, CONFn;
  logic [MUX_W-1:0]  DA;
  logic              RASn, CASn, DWn, RDY, BEn, RLE, WLE;

  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  dram_ctrl_gen #(.ADDR_W(ADDR_W), .REFRESH_CYCLES(RC)) dut (
    .clk(clk), .RESETn(RESETn), .addr(addr), .CSn(CSn), .RWn(RWn), .CONFn(CONFn),
    .DA(DA), .RASn(RASn), .CASn(CASn), .DWn(DWn), .RDY(RDY), .BEn(BEn),
    .RLE(RLE), .WLE(WLE)
  );

  typedef struct packed {
    logic rasn, casn, dwn, rdy, ben, rle, wle;
    logic [MUX_W-1:0] da;
  } obs_t;

  typedef enum {K_IDLE, K_RAS, K_CAS, K_RCAS, K_RRAS} kind_e;

  typedef struct {
    logic csn, rwn, confn;
    logic [ADDR_W-1:0] a;
    obs_t exp;
  } vec_t;

  vec_t vecs[$];

  function automatic obs_t mk(input kind_e k, input logic [MUX_W-1:0] da,
                              input logic rle, input logic wle, input logic dwn);
    obs_t o;
    o = '0;
    o.rasn = 1'b1; o.casn = 1'b1; o.dwn = 1'b1; o.rdy = 1'b1; o.ben = 1'b1;
    o.rle = rle; o.wle = wle; o.da = da;
    case (k)
      K_RAS:  begin o.rasn = 1'b0; o.rdy = 1'b0; o.ben = 1'b0; end
      K_CAS:  begin o.rasn = 1'b0; o.casn = 1'b0; o.rdy = 1'b0; o.ben = 1'b0; o.dwn = dwn; end
      K_RCAS: begin o.casn = 1'b0; o.rdy = 1'b0; end
      K_RRAS: begin o.rasn = 1'b0; o.casn = 1'b0; o.rdy = 1'b0; end
      default: ;
    endcase
    return o;
  endfunction

  function automatic obs_t cur();
    obs_t o;
    o = {RASn, CASn, DWn, RDY, BEn, RLE, WLE, DA};
    return o;
  endfunction

  function automatic string fmt(input obs_t o);
    return $sformatf("rasn=%b casn=%b dwn=%b rdy=%b ben=%b rle=%b wle=%b da=%h",
                     o.rasn, o.casn, o.dwn, o.rdy, o.ben, o.rle, o.wle, o.da);
  endfunction

  task automatic check(input string name, input obs_t act, input obs_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got {%s} expected {%s}", name, fmt(act), fmt(exp));
    end
  endtask

  task automatic add(input logic csn, input logic rwn, input logic confn,
                     input logic [ADDR_W-1:0] a, input kind_e k,
                     input logic [MUX_W-1:0] da, input logic rle, input logic wle,
                     input logic dwn);
    vec_t v;
    v.csn = csn; v.rwn = rwn; v.confn = confn; v.a = a;
    v.exp = mk(k, da, rle, wle, dwn);
    vecs.push_back(v);
  endtask

  // Reference model: each access or refresh is expanded into a schedule of
  // per-cycle output records; requests are decided only when the schedule is empty.
  obs_t        m_q[$];
  logic [7:0]  m_cfg;
  bit          m_armed, m_pend;
  int          m_edge, m_acc, m_ref;
  logic        m_csn, m_rwn, m_confn;
  logic [ADDR_W-1:0] m_addr;

  task automatic model_init();
    m_q.delete();
    m_cfg = 8'h48; m_armed = 1'b1; m_pend = 1'b0; m_edge = 0;
    m_csn = 1'b1; m_rwn = 1'b1; m_confn = 1'b1; m_addr = '0;
  endtask

  task automatic model_edge(output obs_t o);
    int trcd, tcas, trp;
    logic [MUX_W-1:0] row, col;
    m_edge++;
    trcd = int'(m_cfg[2:0]) + 1;
    tcas = int'(m_cfg[5:3]) + 1;
    trp  = int'(m_cfg[7:6]) + 1;
    if (m_q.size() == 0) begin
      if (m_pend) begin
        m_pend = 1'b0;
        m_ref++;
        m_q.push_back(mk(K_RCAS, '0, 1'b0, 1'b0, 1'b1));
        for (int i = 0; i < tcas; i++) m_q.push_back(mk(K_RRAS, '0, 1'b0, 1'b0, 1'b1));
        for (int i = 0; i <= trp; i++) m_q.push_back(mk(K_IDLE, '0, 1'b0, 1'b0, 1'b1));
      end else if (!m_csn && !m_confn) begin
        m_cfg = m_addr[7:0];
      end else if (!m_csn && m_armed) begin
        m_armed = 1'b0;
        m_acc++;
        row = m_addr[ADDR_W-1:MUX_W];
        col = m_addr[MUX_W-1:0];
        for (int i = 0; i < trcd; i++) m_q.push_back(mk(K_RAS, row, 1'b0, (i == 0) && !m_rwn, 1'b1));
        for (int i = 0; i < tcas; i++) m_q.push_back(mk(K_CAS, col, (i == tcas - 1) && m_rwn, 1'b0, m_rwn));
        for (int i = 0; i <= trp; i++) m_q.push_back(mk(K_IDLE, '0, 1'b0, 1'b0, 1'b1));
      end
    end
    if (m_q.size() != 0) o = m_q.pop_front();
    else o = mk(K_IDLE, '0, 1'b0, 1'b0, 1'b1);
    if (m_csn) m_armed = 1'b1;
    if (m_edge % RC == 0) m_pend = 1'b1;
    m_csn = CSn; m_rwn = RWn; m_confn = CONFn; m_addr = addr;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    obs_t exp;
    int n;
    CSn = 1'b1; RWn = 1'b1; CONFn = 1'b1; addr = '0; RESETn = 1'b0;
    m_acc = 0; m_ref = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_state", cur(), mk(K_IDLE, '0, 1'b0, 1'b0, 1'b1));
    RESETn = 1'b1;

    // Default read 16'hA55A (edges 1..6)
    add(0,1,1,16'hA55A, K_IDLE,8'h00,0,0,1);
    add(1,1,1,16'hA55A, K_RAS, 8'hA5,0,0,1);
    add(1,1,1,16'hFFFF, K_CAS, 8'h5A,0,0,1);
    add(1,1,1,16'h0000, K_CAS, 8'h5A,1,0,1);
    add(1,1,1,16'h0000, K_IDLE,8'h00,0,0,1);
    add(1,1,1,16'h0000, K_IDLE,8'h00,0,0,1);
    // Write 16'h1234 (edges 7..12)
    add(0,0,1,16'h1234, K_IDLE,8'h00,0,0,1);
    add(1,1,1,16'h0000, K_RAS, 8'h12,0,1,1);
    add(1,1,1,16'h0000, K_CAS, 8'h34,0,0,0);
    add(1,1,1,16'h0000, K_CAS, 8'h34,0,0,0);
    add(1,1,1,16'h0000, K_IDLE,8'h00,0,0,1);
    add(1,1,1,16'h0000, K_IDLE,8'h00,0,0,1);
    // Config 8'hDB then read: RAS 4, CAS 4, PRE 4 (edges 13..27)
    add(0,1,0,16'h00DB, K_IDLE,8'h00,0,0,1);
    add(1,1,1,16'h0000, K_IDLE,8'h00,0,0,1);
    add(0,1,1,16'hA55A, K_IDLE,8'h00,0,0,1);
    for (int i = 0; i < 4; i++) add(1,1,1,16'h0000, K_RAS, 8'hA5,0,0,1);
    for (int i = 0; i < 3; i++) add(1,1,1,16'h0000, K_CAS, 8'h5A,0,0,1);
    add(1,1,1,16'h0000, K_CAS, 8'h5A,1,0,1);
    for (int i = 0; i < 4; i++) add(1,1,1,16'h0000, K_IDLE,8'h00,0,0,1);
    // Restore default timing (edges 28..31)
    add(0,1,0,16'h0048, K_IDLE,8'h00,0,0,1);
    add(1,1,1,16'h0000, K_IDLE,8'h00,0,0,1);
    add(1,1,1,16'h0000, K_IDLE,8'h00,0,0,1);
    add(1,1,1,16'h0000, K_IDLE,8'h00,0,0,1);
    // CSn held low across the refresh wrap at edge 32: refresh first, then one access
    add(0,1,1,16'h1234, K_IDLE,8'h00,0,0,1);
    add(0,1,1,16'h1234, K_RCAS,8'h00,0,0,1);
    add(0,1,1,16'h1234, K_RRAS,8'h00,0,0,1);
    add(0,1,1,16'h1234, K_RRAS,8'h00,0,0,1);
    add(0,1,1,16'h1234, K_IDLE,8'h00,0,0,1);
    add(0,1,1,16'h1234, K_IDLE,8'h00,0,0,1);
    add(0,1,1,16'h1234, K_IDLE,8'h00,0,0,1);
    add(0,1,1,16'h1234, K_RAS, 8'h12,0,0,1);
    add(0,1,1,16'h1234, K_CAS, 8'h34,0,0,1);
    add(0,1,1,16'h1234, K_CAS, 8'h34,1,0,1);
    add(0,1,1,16'h1234, K_IDLE,8'h00,0,0,1);
    add(0,1,1,16'h1234, K_IDLE,8'h00,0,0,1);
    add(0,1,1,16'h1234, K_IDLE,8'h00,0,0,1);
    add(0,1,1,16'h1234, K_IDLE,8'h00,0,0,1);
    add(1,1,1,16'h0000, K_IDLE,8'h00,0,0,1);

    foreach (vecs[i]) begin
      CSn = vecs[i].csn; RWn = vecs[i].rwn; CONFn = vecs[i].confn; addr = vecs[i].a;
      @(posedge clk);
      @(negedge clk);
      check($sformatf("vec_edge%0d", i + 1), cur(), vecs[i].exp);
    end

    // Asynchronous reset in the middle of a CAS phase
    CSn = 1'b0; RWn = 1'b1; CONFn = 1'b1; addr = 16'hA55A;
    @(posedge clk); @(negedge clk);
    CSn = 1'b1;
    n = 0;
    while (!(CASn === 1'b0 && BEn === 1'b0) && n < 30) begin
      @(posedge clk); @(negedge clk);
      n++;
    end
    checks++;
    if (!(CASn === 1'b0 && BEn === 1'b0)) begin
      errors++;
      $display("FAIL cas_reach: casn=%b ben=%b after %0d cycles, expected casn=0 ben=0", CASn, BEn, n);
    end
    #2 RESETn = 1'b0;
    #1 check("async_reset_mid_cas", cur(), mk(K_IDLE, '0, 1'b0, 1'b0, 1'b1));

    // Randomised traffic against the reference model
    @(negedge clk);
    RESETn = 1'b1;
    model_init();
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 3) == 0) CSn = ~CSn;
      CONFn = ($urandom_range(0, 11) == 0) ? 1'b0 : 1'b1;
      RWn   = 1'($urandom_range(0, 1));
      addr  = ADDR_W'($urandom);
      @(posedge clk);
      model_edge(exp);
      @(negedge clk);
      check($sformatf("rand_cycle%0d", c), cur(), exp);
    end
    checks++;
    if (m_acc < 20 || m_ref < 20) begin
      errors++;
      $display("FAIL rand_activity: accesses=%0d refreshes=%0d, expected at least 20 each", m_acc, m_ref);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
